// File: rtl/rf_wb_arbiter_pkg.sv
// Shared core definitions for the register-file write-port arbiter.
// Register address type, x0 constant and default data width.
package rf_wb_arbiter_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef logic [4:0] regaddr_t;

    localparam regaddr_t REG_X0 = 5'd0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for registers awaiting a MUL/DIV result.
// One set port, one clear port, three-port busy lookup for decode.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  regaddr_t         set_rd,
    input  logic             clr_en,
    input  regaddr_t         clr_rd,
    input  regaddr_t         rs1,
    input  regaddr_t         rs2,
    input  regaddr_t         rd,
    output logic             stall,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is applied after clear so a same-index collision leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign stall = busy_q[rs1] | busy_q[rs2] | busy_q[rd];
    assign busy  = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. MUL/DIV results.
// Holds one MUL/DIV result, tracks busy registers, forces bubbles on starvation.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int XLEN       = rf_wb_arbiter_pkg::XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_we,
    input  regaddr_t        pipe_rd,
    input  logic [XLEN-1:0] pipe_wd,
    input  logic            md_issue,
    input  regaddr_t        md_issue_rd,
    input  logic            md_valid,
    input  regaddr_t        md_rd,
    input  logic [XLEN-1:0] md_wd,
    output logic            md_ready,
    input  regaddr_t        dec_rs1,
    input  regaddr_t        dec_rs2,
    input  regaddr_t        dec_rd,
    output logic            dec_stall,
    output logic            wb_bubble,
    output logic            rf_we,
    output regaddr_t        rf_a3,
    output logic [XLEN-1:0] rf_wd
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic            hold_v_q;
    logic            hold_v_d;
    regaddr_t        hold_rd_q;
    regaddr_t        hold_rd_d;
    logic [XLEN-1:0] hold_wd_q;
    logic [XLEN-1:0] hold_wd_d;
    logic [CW-1:0]   starve_q;
    logic [CW-1:0]   starve_d;

    logic             drain;
    logic             accept;
    logic             load;
    logic [NREGS-1:0] busy;

    assign drain     = hold_v_q & ~pipe_we;
    assign md_ready  = ~hold_v_q | drain;
    assign accept    = md_valid & md_ready;
    assign load      = accept & (md_rd != REG_X0);
    assign wb_bubble = (starve_q >= STARVE_LIM);

    always_comb begin
        rf_we = 1'b0;
        rf_a3 = REG_X0;
        rf_wd = '0;
        if (pipe_we) begin
            rf_we = 1'b1;
            rf_a3 = pipe_rd;
            rf_wd = pipe_wd;
        end else if (hold_v_q) begin
            rf_we = 1'b1;
            rf_a3 = hold_rd_q;
            rf_wd = hold_wd_q;
        end
    end

    // Results for x0 are handshaken but never occupy the hold buffer.
    always_comb begin
        hold_v_d  = hold_v_q;
        hold_rd_d = hold_rd_q;
        hold_wd_d = hold_wd_q;
        if (load) begin
            hold_v_d  = 1'b1;
            hold_rd_d = md_rd;
            hold_wd_d = md_wd;
        end else if (drain) begin
            hold_v_d = 1'b0;
        end
    end

    always_comb begin
        starve_d = '0;
        if (hold_v_q && pipe_we) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v_q  <= 1'b0;
            hold_rd_q <= REG_X0;
            hold_wd_q <= '0;
            starve_q  <= '0;
        end else begin
            hold_v_q  <= hold_v_d;
            hold_rd_q <= hold_rd_d;
            hold_wd_q <= hold_wd_d;
            starve_q  <= starve_d;
        end
    end

    rf_scoreboard u_sb (
        .clk    (clk),
        .rst    (rst),
        .set_en (md_issue & (md_issue_rd != REG_X0)),
        .set_rd (md_issue_rd),
        .clr_en (drain),
        .clr_rd (hold_rd_q),
        .rs1    (dec_rs1),
        .rs2    (dec_rs2),
        .rd     (dec_rd),
        .stall  (dec_stall),
        .busy   (busy)
    );

`ifndef SYNTHESIS
    a_issue_stalled: assert property (
        @(posedge clk) disable iff (rst) !(md_issue && dec_stall)
    ) else $error("md_issue asserted while dec_stall");

    a_pipe_busy_rd: assert property (
        @(posedge clk) disable iff (rst)
        !(pipe_we && pipe_rd != REG_X0 && busy[pipe_rd])
    ) else $error("pipeline write to busy rd %0d", pipe_rd);

    a_md_rd_busy: assert property (
        @(posedge clk) disable iff (rst)
        !(accept && md_rd != REG_X0 && !busy[md_rd])
    ) else $error("MUL/DIV result for non-busy rd %0d", md_rd);
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, hand sequences,
// and a randomized run against a queue-based reference model.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int SMAX = 4;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    regaddr_t    pipe_rd;
    logic [31:0] pipe_wd;
    logic        md_issue;
    regaddr_t    md_issue_rd;
    logic        md_valid;
    regaddr_t    md_rd;
    logic [31:0] md_wd;
    logic        md_ready;
    regaddr_t    dec_rs1;
    regaddr_t    dec_rs2;
    regaddr_t    dec_rd;
    logic        dec_stall;
    logic        wb_bubble;
    logic        rf_we;
    regaddr_t    rf_a3;
    logic [31:0] rf_wd;

    int n_cmp = 0;
    int n_bad = 0;

    rf_wb_arbiter #(.XLEN(32), .STARVE_MAX(SMAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_wd     (pipe_wd),
        .md_issue    (md_issue),
        .md_issue_rd (md_issue_rd),
        .md_valid    (md_valid),
        .md_rd       (md_rd),
        .md_wd       (md_wd),
        .md_ready    (md_ready),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_stall   (dec_stall),
        .wb_bubble   (wb_bubble),
        .rf_we       (rf_we),
        .rf_a3       (rf_a3),
        .rf_wd       (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          pwe;
        logic [4:0]  prd;
        logic [31:0] pwd;
        bit          iss;
        logic [4:0]  ird;
        bit          mv;
        logic [4:0]  mrd;
        logic [31:0] mwd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  drd;
        bit          rdy;
        bit          stl;
        bit          we;
        logic [4:0]  a3;
        logic [31:0] wd;
        bit          bub;
    } vec_t;

    typedef struct {
        regaddr_t    rd;
        logic [31:0] wd;
    } res_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
        md_issue = 0; md_issue_rd = 0;
        md_valid = 0; md_rd = 0; md_wd = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    endtask

    task automatic check_all(input string tag, input bit rdy, input bit stl,
                             input bit we, input logic [4:0] a3,
                             input logic [31:0] wd, input bit bub);
        chk({tag, ".md_ready"}, 32'(md_ready), 32'(rdy));
        chk({tag, ".dec_stall"}, 32'(dec_stall), 32'(stl));
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(we));
        chk({tag, ".rf_a3"}, 32'(rf_a3), 32'(a3));
        chk({tag, ".rf_wd"}, rf_wd, wd);
        chk({tag, ".wb_bubble"}, 32'(wb_bubble), 32'(bub));
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        @(negedge clk);
        #1;
        check_all("reset", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 0;
    endtask

    // Reference model state
    bit   mbusy[32];
    res_t hq[$];
    int   starve;
    bit   bub_prev;
    regaddr_t pend[$];
    bit          mv_on;
    regaddr_t    mv_rd;
    logic [31:0] mv_wd;

    task automatic model_clear();
        foreach (mbusy[i]) mbusy[i] = 0;
        hq.delete();
        pend.delete();
        starve = 0;
        bub_prev = 0;
        mv_on = 0;
    endtask

    task automatic random_run(input int cycles);
        bit e_drain, e_rdy, e_stl, e_we, e_bub;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        res_t r;
        for (int c = 0; c < cycles; c++) begin
            if (!mv_on && pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                mv_on = 1;
                mv_rd = pend.pop_front();
                mv_wd = $urandom;
            end else if (!mv_on && $urandom_range(0, 15) == 0) begin
                mv_on = 1;
                mv_rd = 0;
                mv_wd = $urandom;
            end
            md_valid = mv_on;
            md_rd    = mv_on ? mv_rd : 5'd0;
            md_wd    = mv_on ? mv_wd : 32'd0;
            pipe_we  = !bub_prev && ($urandom_range(0, 3) != 0);
            pipe_rd  = 5'($urandom_range(0, 7));
            if (mbusy[pipe_rd]) pipe_rd = 0;
            pipe_wd  = $urandom;
            dec_rs1  = 5'($urandom_range(0, 7));
            dec_rs2  = 5'($urandom_range(0, 7));
            dec_rd   = 5'($urandom_range(0, 7));
            e_stl = mbusy[dec_rs1] | mbusy[dec_rs2] | mbusy[dec_rd];
            md_issue = !e_stl && pend.size() < 4 && $urandom_range(0, 3) == 0;
            md_issue_rd = dec_rd;

            e_drain = (hq.size() > 0) && !pipe_we;
            e_rdy   = (hq.size() == 0) || e_drain;
            e_bub   = starve >= SMAX;
            if (pipe_we) begin
                e_we = 1; e_a3 = pipe_rd; e_wd = pipe_wd;
            end else if (hq.size() > 0) begin
                e_we = 1; e_a3 = hq[0].rd; e_wd = hq[0].wd;
            end else begin
                e_we = 0; e_a3 = 0; e_wd = 0;
            end
            #1;
            check_all("rand", e_rdy, e_stl, e_we, e_a3, e_wd, e_bub);

            if (hq.size() > 0 && pipe_we) starve = (starve < SMAX) ? starve + 1 : SMAX;
            else starve = 0;
            if (e_drain) begin
                r = hq.pop_front();
                mbusy[r.rd] = 0;
            end
            if (md_issue && dec_rd != 0) begin
                mbusy[dec_rd] = 1;
                pend.push_back(dec_rd);
            end
            if (mv_on && e_rdy) begin
                if (mv_rd != 0) hq.push_back('{mv_rd, mv_wd});
                mv_on = 0;
            end
            bub_prev = e_bub;
            @(negedge clk);
        end
    endtask

    initial begin
        tbl[0]  = '{0,0,0, 1,5, 0,0,0,            0,0,5, 1,0,0,0,0,0};
        tbl[1]  = '{0,0,0, 0,0, 0,0,0,            0,5,0, 1,1,0,0,0,0};
        tbl[2]  = '{0,0,0, 0,0, 0,0,0,            0,5,0, 1,1,0,0,0,0};
        tbl[3]  = '{0,0,0, 0,0, 1,5,32'hDEADBEEF, 0,5,0, 1,1,0,0,0,0};
        tbl[4]  = '{0,0,0, 0,0, 0,0,0,            0,5,0, 1,1,1,5,32'hDEADBEEF,0};
        tbl[5]  = '{0,0,0, 0,0, 0,0,0,            0,5,0, 1,0,0,0,0,0};
        tbl[6]  = '{0,0,0, 1,6, 0,0,0,            0,0,6, 1,0,0,0,0,0};
        tbl[7]  = '{0,0,0, 1,7, 0,0,0,            0,0,7, 1,0,0,0,0,0};
        tbl[8]  = '{0,0,0, 0,0, 1,6,32'h11111111, 6,0,0, 1,1,0,0,0,0};
        tbl[9]  = '{0,0,0, 0,0, 1,7,32'h22222222, 6,0,0, 1,1,1,6,32'h11111111,0};
        tbl[10] = '{0,0,0, 0,0, 0,0,0,            7,0,0, 1,1,1,7,32'h22222222,0};
        tbl[11] = '{0,0,0, 0,0, 0,0,0,            6,7,0, 1,0,0,0,0,0};
        tbl[12] = '{0,0,0, 1,0, 1,0,32'h00000BAD, 0,0,0, 1,0,0,0,0,0};
        tbl[13] = '{0,0,0, 0,0, 0,0,0,            0,0,0, 1,0,0,0,0,0};
        tbl[14] = '{1,3,32'h33, 0,0, 0,0,0,       3,0,0, 1,0,1,3,32'h33,0};
        tbl[15] = '{0,0,0, 1,8, 0,0,0,            0,0,8, 1,0,0,0,0,0};
        tbl[16] = '{1,2,32'h22, 0,0, 1,8,32'h88,  0,0,0, 1,0,1,2,32'h22,0};
        tbl[17] = '{1,4,32'h44, 0,0, 0,0,0,       0,0,8, 0,1,1,4,32'h44,0};
        tbl[18] = '{0,0,0, 0,0, 0,0,0,            0,0,8, 1,1,1,8,32'h88,0};
        tbl[19] = '{0,0,0, 0,0, 0,0,0,            0,0,8, 1,0,0,0,0,0};

        rst = 1;
        idle();
        do_reset();

        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            pipe_we = tbl[i].pwe; pipe_rd = tbl[i].prd; pipe_wd = tbl[i].pwd;
            md_issue = tbl[i].iss; md_issue_rd = tbl[i].ird;
            md_valid = tbl[i].mv; md_rd = tbl[i].mrd; md_wd = tbl[i].mwd;
            dec_rs1 = tbl[i].rs1; dec_rs2 = tbl[i].rs2; dec_rd = tbl[i].drd;
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].stl,
                      tbl[i].we, tbl[i].a3, tbl[i].wd, tbl[i].bub);
            @(negedge clk);
        end

        // Contention: pipeline writes every cycle until told to bubble
        idle();
        md_issue = 1; md_issue_rd = 10; dec_rd = 10;
        @(negedge clk);
        idle();
        md_valid = 1; md_rd = 10; md_wd = 32'hA5A5A5A5;
        pipe_we = 1; pipe_rd = 1; pipe_wd = 32'h1;
        #1;
        chk("cont.accept", 32'(md_ready), 1);
        @(negedge clk);
        md_valid = 0; md_rd = 0; md_wd = 0;
        for (int k = 1; k <= SMAX; k++) begin
            pipe_we = 1; pipe_rd = 5'(k); pipe_wd = 32'(k);
            #1;
            chk($sformatf("cont.bub%0d", k), 32'(wb_bubble), 0);
            chk($sformatf("cont.rdy%0d", k), 32'(md_ready), 0);
            chk($sformatf("cont.a3_%0d", k), 32'(rf_a3), 32'(k));
            @(negedge clk);
        end
        pipe_we = 1; pipe_rd = 1;
        #1;
        chk("cont.bubble", 32'(wb_bubble), 1);
        @(negedge clk);
        pipe_we = 0;
        #1;
        chk("cont.drain_we", 32'(rf_we), 1);
        chk("cont.drain_a3", 32'(rf_a3), 10);
        chk("cont.drain_wd", rf_wd, 32'hA5A5A5A5);
        @(negedge clk);
        dec_rs1 = 10;
        #1;
        chk("cont.stall_after", 32'(dec_stall), 0);
        chk("cont.bub_after", 32'(wb_bubble), 0);
        @(negedge clk);

        // Reset while a result sits in the hold buffer
        idle();
        md_issue = 1; md_issue_rd = 9; dec_rd = 9;
        @(negedge clk);
        idle();
        md_valid = 1; md_rd = 9; md_wd = 32'h99; pipe_we = 1; pipe_rd = 1;
        @(negedge clk);
        md_valid = 0; md_rd = 0; md_wd = 0;
        #1;
        chk("rsthold.rdy_pre", 32'(md_ready), 0);
        #2 rst = 1;
        #1 pipe_we = 0; dec_rs1 = 9;
        #1;
        chk("rsthold.rdy", 32'(md_ready), 1);
        chk("rsthold.we", 32'(rf_we), 0);
        chk("rsthold.stall", 32'(dec_stall), 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rsthold.we_post", 32'(rf_we), 0);
        chk("rsthold.stall_post", 32'(dec_stall), 0);
        @(negedge clk);

        do_reset();
        model_clear();
        @(negedge clk);
        random_run(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
